if_id_queue: RTL and testbench
==============================

IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 Parameter WIDTH, default 32: width of the instruction and PC fields.
REQ-002 Parameter DEPTH, default 4: number of queue entries; power of two, at least 2.
REQ-003 Parameter NOP_VAL, default 32'h0000_0013: instruction presented when no valid entry exists.
REQ-004 Parameter PC_RST_VAL, default 32'h0000_0000: PC and PC+4 value presented when no valid entry exists.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 in_valid  input  1  IF offers an entry this cycle.
REQ-008 in_ready  output  1  queue accepts an entry this cycle.
REQ-009 instr_if, pc_if, pc_plus4_if  input  WIDTH each  fetched entry fields.
REQ-010 stall_id  input  1  ID holds its current entry; no pop.
REQ-011 bubble_id  input  1  flush; discard all queued entries.
REQ-012 instr_id, pc_id, pc_plus4_id  output  WIDTH each  head entry presented to ID.
REQ-013 valid_id  output  1  head outputs carry a real entry.
REQ-014 count  output  $clog2(DEPTH+1)  current occupancy.

Function
REQ-015 The queue SHALL be a circular buffer with read and write pointers of $clog2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-016 in_ready SHALL equal (count != DEPTH), combinationally from registered state only.
REQ-017 A push SHALL occur when in_valid && in_ready && !bubble_id: the entry is written at the write pointer and the write pointer is incremented.
REQ-018 A pop SHALL occur when valid_id && !stall_id && !bubble_id: the read pointer is incremented.
REQ-019 The head outputs SHALL be read combinationally from the entry at the read pointer when count != 0, with valid_id=1.
REQ-020 When count == 0, the outputs SHALL be instr_id=NOP_VAL, pc_id=PC_RST_VAL, pc_plus4_id=PC_RST_VAL and valid_id=0.
REQ-021 A simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-022 When full, in_ready=0; a pop in the same cycle SHALL NOT enable a push in that cycle.
REQ-023 With the macro undefined, push-to-visible latency SHALL be 1 cycle: an entry pushed at edge N appears at the head after edge N if the queue was empty.
REQ-024 bubble_id SHALL have priority over stall_id, push and pop; at the next edge both pointers and count are 0, and any same-cycle push is discarded.
REQ-025 While stall_id=1 and bubble_id=0, the head outputs SHALL remain stable and pushes SHALL continue until the queue is full.
REQ-026 Entry storage SHALL NOT require reset; only pointers and count are reset.

Reset
REQ-027 When rst=1 at a rising edge, the read pointer, the write pointer and count SHALL become 0; this takes priority over all other inputs.
REQ-028 After reset, the outputs SHALL be in_ready=1, valid_id=0, instr_id=NOP_VAL, pc_id=PC_RST_VAL, pc_plus4_id=PC_RST_VAL and count=0.
REQ-029 A reset asserted mid-operation SHALL discard all entries, with no partial push or pop.

Configuration
REQ-030 With macro IF_ID_QUEUE_BYPASS_EN defined and count == 0, the head outputs SHALL show the *_if inputs combinationally, with valid_id=in_valid.
REQ-031 In that bypass case, an entry with !stall_id and !bubble_id SHALL be consumed without being written (no count change); with stall_id=1 it SHALL be pushed normally.
REQ-032 With IF_ID_QUEUE_BYPASS_EN undefined, the REQ-020 and REQ-023 behaviour SHALL apply unchanged.

Verification
REQ-033 Reset, then idle -> valid_id=0, instr_id=32'h0000_0013, pc_id=0, in_ready=1, count=0.
REQ-034 Push pc_if=0x100,0x104,0x108,0x10C with stall_id=1 -> count=4, in_ready=0, pc_id=0x100; a fifth offer is not accepted.
REQ-035 From full, release stall_id with in_valid=0 -> pc_id sequence 0x100,0x104,0x108,0x10C on successive cycles, then valid_id=0 and instr_id=NOP_VAL.
REQ-036 Continuous push/pop over 10 entries (wrap-around) with stall_id=0 -> in-order delivery, count steady at 1 (0 with bypass).
REQ-037 bubble_id=1 with count=3, stall_id=1 and in_valid=1 -> next cycle count=0 and valid_id=0; the offered entry is absent.
REQ-038 Bypass build, queue empty, in_valid=1, pc_if=0x200, stall_id=0 -> same-cycle pc_id=0x200, valid_id=1, count stays 0.

Source files
------------

// File: rtl/if_id_queue.sv
// IF/ID decoupling queue: circular buffer of fetched {instr, pc, pc+4} entries (optional macro IF_ID_QUEUE_BYPASS_EN).
// Latency: push-to-head 1 cycle into an empty queue; 0 cycles with IF_ID_QUEUE_BYPASS_EN defined.
// Backpressure: in_ready drops only when full; stall_id holds the head, bubble_id flushes everything.
module if_id_queue #(
    parameter int               WIDTH      = 32,
    parameter int               DEPTH      = 4,
    parameter logic [WIDTH-1:0] NOP_VAL    = 32'h0000_0013,
    parameter logic [WIDTH-1:0] PC_RST_VAL = 32'h0000_0000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             instr_if,
    input  logic [WIDTH-1:0]             pc_if,
    input  logic [WIDTH-1:0]             pc_plus4_if,
    input  logic                         stall_id,
    input  logic                         bubble_id,
    output logic [WIDTH-1:0]             instr_id,
    output logic [WIDTH-1:0]             pc_id,
    output logic [WIDTH-1:0]             pc_plus4_id,
    output logic                         valid_id,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef struct packed {
        logic [WIDTH-1:0] instr;
        logic [WIDTH-1:0] pc;
        logic [WIDTH-1:0] pc_plus4;
    } entry_t;

    // Entry storage carries no reset; only pointers and occupancy define validity.
    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q,  count_d;

    entry_t          head;
    entry_t          in_ent;
    logic            empty;
    logic            byp_take;
    logic            push;
    logic            pop;

    assign empty    = (count_q == '0);
    assign in_ready = (count_q != FULL_CNT);
    assign count    = count_q;
    assign head     = mem_q[rd_ptr_q];
    assign in_ent   = '{instr: instr_if, pc: pc_if, pc_plus4: pc_plus4_if};

    // Head presentation: stored entry when occupied, otherwise idle value or bypassed fetch.
    always_comb begin
        instr_id    = head.instr;
        pc_id       = head.pc;
        pc_plus4_id = head.pc_plus4;
        valid_id    = 1'b1;
        byp_take    = 1'b0;
        if (empty) begin
`ifdef IF_ID_QUEUE_BYPASS_EN
            instr_id    = instr_if;
            pc_id       = pc_if;
            pc_plus4_id = pc_plus4_if;
            valid_id    = in_valid;
            // ID consumes the fetched entry directly, so it must not also be stored.
            byp_take    = in_valid && !stall_id && !bubble_id;
`else
            instr_id    = NOP_VAL;
            pc_id       = PC_RST_VAL;
            pc_plus4_id = PC_RST_VAL;
            valid_id    = 1'b0;
`endif
        end
    end

    // Push/pop decisions and next pointer/occupancy state; flush wins over everything.
    always_comb begin
        push     = in_valid && in_ready && !bubble_id && !byp_take;
        pop      = !empty && !stall_id && !bubble_id;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (bubble_id) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry write at the write pointer; suppressed during reset so no partial push lands.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_q[wr_ptr_q] <= in_ent;
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
module tb_if_id_queue;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] K   = 32'hA5A5_0000;
`ifdef IF_ID_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk, rst, in_valid, in_ready, stall_id, bubble_id, valid_id;
    logic [31:0] instr_if, pc_if, pc_plus4_if, instr_id, pc_id, pc_plus4_id;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    if_id_queue dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instr_if(instr_if), .pc_if(pc_if), .pc_plus4_if(pc_plus4_if),
        .stall_id(stall_id), .bubble_id(bubble_id),
        .instr_id(instr_id), .pc_id(pc_id), .pc_plus4_id(pc_plus4_id),
        .valid_id(valid_id), .count(count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: a plain queue of entries.
    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc;
        logic [31:0] pc4;
    } ent_t;
    ent_t mq[$];

    typedef struct {
        bit          vld;
        bit          stl;
        bit          bub;
        logic [31:0] pc;
        bit          ev;
        logic [31:0] epc;
        int          ecnt;
        bit          erdy;
    } vec_t;
    vec_t tbl[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit r, input bit v, input bit s, input bit b, input logic [31:0] pc);
        rst         = r;
        in_valid    = v;
        stall_id    = s;
        bubble_id   = b;
        pc_if       = pc;
        instr_if    = pc ^ K;
        pc_plus4_if = pc + 32'd4;
        #1;
    endtask

    // Compare combinational outputs against the model for the inputs now applied.
    task automatic check_model();
        logic [31:0] ei, ep, e4;
        logic        ev;
        int          n;
        n = mq.size();
        if (n > 0) begin
            ev = 1'b1; ei = mq[0].ins; ep = mq[0].pc; e4 = mq[0].pc4;
        end else if (BYP) begin
            ev = in_valid; ei = instr_if; ep = pc_if; e4 = pc_plus4_if;
        end else begin
            ev = 1'b0; ei = NOP; ep = 32'h0; e4 = 32'h0;
        end
        chk("m_count", {29'd0, count}, n);
        chk("m_in_ready", {31'd0, in_ready}, {31'd0, n != 4});
        chk("m_valid_id", {31'd0, valid_id}, {31'd0, ev});
        chk("m_instr_id", instr_id, ei);
        chk("m_pc_id", pc_id, ep);
        chk("m_pc_plus4_id", pc_plus4_id, e4);
    endtask

    // Advance model with current inputs, then clock the DUT.
    task automatic tick();
        int  n;
        bit  rdy, take, pushm, popm;
        n = mq.size();
        if (rst || bubble_id) begin
            mq.delete();
        end else begin
            rdy   = (n != 4);
            popm  = (n > 0) && !stall_id;
            take  = BYP && (n == 0) && in_valid && !stall_id;
            pushm = in_valid && rdy && !take;
            if (popm) void'(mq.pop_front());
            if (pushm) mq.push_back('{instr_if, pc_if, pc_plus4_if});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1, 0, 0, 0, 32'h0);
        tick();
        tick();
        drive(0, 0, 0, 0, 32'h0);
    endtask

    initial begin
        logic [31:0] pcs [10];
        int          idx;

        // {vld, stall, bubble, pc_if} -> {valid, pc_id, count, in_ready}, sampled before the edge
        tbl[0]  = '{0, 0, 0, 32'h000, 0, 32'h000, 0, 1};
        tbl[1]  = '{1, 1, 0, 32'h100, 0, 32'h000, 0, 1};
        tbl[2]  = '{1, 1, 0, 32'h104, 1, 32'h100, 1, 1};
        tbl[3]  = '{1, 1, 0, 32'h108, 1, 32'h100, 2, 1};
        tbl[4]  = '{1, 1, 0, 32'h10C, 1, 32'h100, 3, 1};
        tbl[5]  = '{1, 1, 0, 32'h110, 1, 32'h100, 4, 0};
        tbl[6]  = '{0, 1, 0, 32'h000, 1, 32'h100, 4, 0};
        tbl[7]  = '{0, 0, 0, 32'h000, 1, 32'h100, 4, 0};
        tbl[8]  = '{0, 0, 0, 32'h000, 1, 32'h104, 3, 1};
        tbl[9]  = '{0, 0, 0, 32'h000, 1, 32'h108, 2, 1};
        tbl[10] = '{0, 0, 0, 32'h000, 1, 32'h10C, 1, 1};
        tbl[11] = '{0, 0, 0, 32'h000, 0, 32'h000, 0, 1};
        tbl[12] = '{1, 1, 0, 32'h200, 0, 32'h000, 0, 1};
        tbl[13] = '{1, 1, 0, 32'h204, 1, 32'h200, 1, 1};
        tbl[14] = '{1, 1, 0, 32'h208, 1, 32'h200, 2, 1};
        tbl[15] = '{1, 1, 1, 32'h20C, 1, 32'h200, 3, 1};
        tbl[16] = '{0, 0, 0, 32'h000, 0, 32'h000, 0, 1};

        drive(1, 0, 0, 0, 32'h0);
        @(posedge clk);
        #1;
        do_reset();

`ifndef IF_ID_QUEUE_BYPASS_EN
        // Fill under stall, drain in order, then flush with a same-cycle offer.
        for (int i = 0; i < 17; i++) begin
            drive(0, tbl[i].vld, tbl[i].stl, tbl[i].bub, tbl[i].pc);
            chk($sformatf("t%0d_valid", i), {31'd0, valid_id}, {31'd0, tbl[i].ev});
            chk($sformatf("t%0d_pc", i), pc_id, tbl[i].epc);
            chk($sformatf("t%0d_instr", i), instr_id, tbl[i].ev ? (tbl[i].epc ^ K) : NOP);
            chk($sformatf("t%0d_pc4", i), pc_plus4_id, tbl[i].ev ? (tbl[i].epc + 32'd4) : 32'h0);
            chk($sformatf("t%0d_count", i), {29'd0, count}, tbl[i].ecnt);
            chk($sformatf("t%0d_ready", i), {31'd0, in_ready}, {31'd0, tbl[i].erdy});
            tick();
        end
`else
        // Bypass: empty queue hands the fetch straight through.
        drive(0, 1, 0, 0, 32'h200);
        chk("byp_pc", pc_id, 32'h200);
        chk("byp_valid", {31'd0, valid_id}, 32'd1);
        chk("byp_count", {29'd0, count}, 32'd0);
        tick();
        drive(0, 0, 0, 0, 32'h0);
        chk("byp_count_after", {29'd0, count}, 32'd0);
        chk("byp_valid_after", {31'd0, valid_id}, 32'd0);
        drive(0, 1, 1, 0, 32'h240);
        tick();
        drive(0, 0, 1, 0, 32'h0);
        chk("byp_stall_push_count", {29'd0, count}, 32'd1);
        chk("byp_stall_push_pc", pc_id, 32'h240);
        tick();
        do_reset();
`endif

        // Streaming through the wrap point: in-order delivery at steady occupancy.
        for (int i = 0; i < 10; i++) pcs[i] = 32'h300 + 32'(i * 4);
        for (int i = 0; i < 10; i++) begin
            drive(0, 1, 0, 0, pcs[i]);
            if (BYP || i > 0) begin
                idx = BYP ? i : i - 1;
                chk($sformatf("s%0d_pc", i), pc_id, pcs[idx]);
                chk($sformatf("s%0d_valid", i), {31'd0, valid_id}, 32'd1);
            end
            chk($sformatf("s%0d_count", i), {29'd0, count}, (BYP || i == 0) ? 0 : 1);
            tick();
        end
        drive(0, 0, 0, 0, 32'h0);
        chk("s_tail_count", {29'd0, count}, BYP ? 0 : 1);
        tick();
        check_model();

        // Full queue with a same-cycle pop: the offer must still be refused.
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 1, 0, 32'h400 + 32'(i * 4));
            tick();
        end
        drive(0, 1, 0, 0, 32'h4F0);
        chk("full_pop_ready", {31'd0, in_ready}, 32'd0);
        tick();
        drive(0, 0, 1, 0, 32'h0);
        chk("full_pop_count", {29'd0, count}, 32'd3);
        check_model();
        tick();

        // Randomized traffic, including mid-run resets and flushes.
        for (int c = 0; c < 800; c++) begin
            drive($urandom_range(0, 63) == 0, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0, $urandom);
            check_model();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
